// File: rtl/pc_unit_if.sv
// Fetch-side bus of the program counter: control inputs, current PC and stack status.
// PC_BRANCH_TRACE_EN adds the br_src/br_vld trace signals.
interface pc_unit_if #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4
);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic              stall;
  logic [2:0]        pc_op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] addr_code;
  logic [CW-1:0]     stk_cnt;
  logic              stk_ovf;
  logic              stk_unf;
  logic              op_err;
`ifdef PC_BRANCH_TRACE_EN
  logic [ADDR_W-1:0] br_src;
  logic              br_vld;

  modport master (
    output stall, pc_op, target, offset,
    input  addr_code, stk_cnt, stk_ovf, stk_unf, op_err, br_src, br_vld
  );
  modport slave (
    input  stall, pc_op, target, offset,
    output addr_code, stk_cnt, stk_ovf, stk_unf, op_err, br_src, br_vld
  );
`else
  modport master (
    output stall, pc_op, target, offset,
    input  addr_code, stk_cnt, stk_ovf, stk_unf, op_err
  );
  modport slave (
    input  stall, pc_op, target, offset,
    output addr_code, stk_cnt, stk_ovf, stk_unf, op_err
  );
`endif
endinterface

// File: rtl/pc_unit.sv
// Program counter with hold/inc/branch/jump/call/ret control and a return-address stack.
// Optional branch trace (br_src/br_vld) enabled by defining PC_BRANCH_TRACE_EN.
module pc_unit #(
  parameter int ADDR_W      = 16,
  parameter int STEP        = 1,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);
  localparam logic [CW-1:0]     FULL_V  = CW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101
  } pc_op_e;

  logic [ADDR_W-1:0] r_pc;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic              r_unf;
  logic              r_err;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0] w_next_pc;
  logic [CW-1:0]     w_next_cnt;
  logic              w_push;
  logic              w_ovf;
  logic              w_unf;
  logic              w_err;
  logic              w_taken;
  logic [CW-1:0]     w_top_cnt;
  logic [IW-1:0]     w_push_idx;
  logic [IW-1:0]     w_pop_idx;

  // Push writes slot stk_cnt, pop reads slot stk_cnt-1 (only used when count is in range).
  assign w_top_cnt  = r_cnt - CW'(1);
  assign w_push_idx = IW'(r_cnt);
  assign w_pop_idx  = IW'(w_top_cnt);

  always_comb begin
    w_next_pc  = r_pc;
    w_next_cnt = r_cnt;
    w_push     = 1'b0;
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    w_err      = 1'b0;
    w_taken    = 1'b0;
    if (!bus.stall) begin
      case (bus.pc_op)
        OP_HOLD:   ;
        OP_INC:    w_next_pc = r_pc + STEP_V;
        OP_BRANCH: begin
          w_next_pc = r_pc + bus.offset;
          w_taken   = 1'b1;
        end
        OP_JUMP: begin
          w_next_pc = bus.target;
          w_taken   = 1'b1;
        end
        OP_CALL: begin
          w_next_pc = bus.target;
          w_taken   = 1'b1;
          if (r_cnt == FULL_V) begin
            w_ovf = 1'b1;
          end else begin
            w_push     = 1'b1;
            w_next_cnt = r_cnt + CW'(1);
          end
        end
        OP_RET: begin
          if (r_cnt == '0) begin
            w_unf = 1'b1;
          end else begin
            w_next_pc  = r_stack[w_pop_idx];
            w_next_cnt = w_top_cnt;
            w_taken    = 1'b1;
          end
        end
        default:   w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_V;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_next_pc;
      r_cnt <= w_next_cnt;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
      r_err <= w_err;
    end
  end

  // Stack contents need no reset: entries above stk_cnt are never read.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[w_push_idx] <= r_pc + STEP_V;
    end
  end

  assign bus.addr_code = r_pc;
  assign bus.stk_cnt   = r_cnt;
  assign bus.stk_ovf   = r_ovf;
  assign bus.stk_unf   = r_unf;
  assign bus.op_err    = r_err;

`ifdef PC_BRANCH_TRACE_EN
  logic [ADDR_W-1:0] r_br_src;
  logic              r_br_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_src <= RESET_V;
      r_br_vld <= 1'b0;
    end else if (w_taken) begin
      r_br_src <= r_pc;
      r_br_vld <= 1'b1;
    end
  end

  assign bus.br_src = r_br_src;
  assign bus.br_vld = r_br_vld;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, increment, branch/wrap, call/return, stack limits,
// stall, reserved ops and mid-run reset, with optional branch-trace checks.
module tb_pc_unit;
  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, BRANCH = 3'b010, JUMP = 3'b011,
                         CALL = 3'b100, RET = 3'b101, RSV0 = 3'b110, RSV1 = 3'b111;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pc_unit_if #(.ADDR_W(16), .STACK_DEPTH(4)) bus ();

  pc_unit #(.ADDR_W(16), .STEP(1), .RESET_ADDR(0), .STACK_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic r, input logic s, input logic [2:0] op,
                      input logic [15:0] tgt, input logic [15:0] off);
    @(negedge clk);
    rst        = r;
    bus.stall  = s;
    bus.pc_op  = op;
    bus.target = tgt;
    bus.offset = off;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [15:0] pc, input logic [2:0] cnt,
                            input logic ovf, input logic unf, input logic err);
    check({tag, ".pc"},  32'(bus.addr_code), 32'(pc));
    check({tag, ".cnt"}, 32'(bus.stk_cnt),   32'(cnt));
    check({tag, ".ovf"}, 32'(bus.stk_ovf),   32'(ovf));
    check({tag, ".unf"}, 32'(bus.stk_unf),   32'(unf));
    check({tag, ".err"}, 32'(bus.op_err),    32'(err));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.stall  = 1'b0;
    bus.pc_op  = HOLD;
    bus.target = '0;
    bus.offset = '0;

    // Reset and increment
    step(1, 0, INC, 16'h0000, 16'h0000);
    step(1, 0, INC, 16'h0000, 16'h0000);
    expect_all("reset", 16'h0000, 3'd0, 0, 0, 0);
`ifdef PC_BRANCH_TRACE_EN
    check("trace_rst_vld", 32'(bus.br_vld), 32'h0);
    check("trace_rst_src", 32'(bus.br_src), 32'h0);
`endif
    step(0, 0, INC, 16'h0000, 16'h0000);
    expect_all("inc1", 16'h0001, 3'd0, 0, 0, 0);
    step(0, 0, INC, 16'h0000, 16'h0000);
    expect_all("inc2", 16'h0002, 3'd0, 0, 0, 0);
    step(0, 0, INC, 16'h0000, 16'h0000);
    expect_all("inc3", 16'h0003, 3'd0, 0, 0, 0);

    // Branch backwards, forwards, and wrap on increment
    step(0, 0, JUMP, 16'h0010, 16'h0000);
    expect_all("jump10", 16'h0010, 3'd0, 0, 0, 0);
    step(0, 0, BRANCH, 16'h0000, 16'hFFF8);
    expect_all("br_neg", 16'h0008, 3'd0, 0, 0, 0);
    step(0, 0, BRANCH, 16'h0000, 16'h0004);
    expect_all("br_pos", 16'h000C, 3'd0, 0, 0, 0);
    step(0, 0, JUMP, 16'hFFFF, 16'h0000);
    expect_all("jumpffff", 16'hFFFF, 3'd0, 0, 0, 0);
    step(0, 0, INC, 16'h0000, 16'h0000);
    expect_all("inc_wrap", 16'h0000, 3'd0, 0, 0, 0);

    // Call / return
    step(0, 0, JUMP, 16'h0020, 16'h0000);
    step(0, 0, CALL, 16'h0100, 16'h0000);
    expect_all("call1", 16'h0100, 3'd1, 0, 0, 0);
    step(0, 0, INC, 16'h0000, 16'h0000);
    expect_all("call_inc", 16'h0101, 3'd1, 0, 0, 0);
    step(0, 0, RET, 16'h0000, 16'h0000);
    expect_all("ret1", 16'h0021, 3'd0, 0, 0, 0);

    // Fill the stack, overflow, drain, underflow
    step(0, 0, CALL, 16'h0200, 16'h0000);
    expect_all("fill1", 16'h0200, 3'd1, 0, 0, 0);
    step(0, 0, CALL, 16'h0300, 16'h0000);
    expect_all("fill2", 16'h0300, 3'd2, 0, 0, 0);
    step(0, 0, CALL, 16'h0400, 16'h0000);
    expect_all("fill3", 16'h0400, 3'd3, 0, 0, 0);
    step(0, 0, CALL, 16'h0500, 16'h0000);
    expect_all("fill4", 16'h0500, 3'd4, 0, 0, 0);
    step(0, 0, CALL, 16'h0600, 16'h0000);
    expect_all("ovf", 16'h0600, 3'd4, 1, 0, 0);
    step(0, 0, RET, 16'h0000, 16'h0000);
    expect_all("pop4", 16'h0401, 3'd3, 0, 0, 0);
    step(0, 0, RET, 16'h0000, 16'h0000);
    expect_all("pop3", 16'h0301, 3'd2, 0, 0, 0);
    step(0, 0, RET, 16'h0000, 16'h0000);
    expect_all("pop2", 16'h0201, 3'd1, 0, 0, 0);
    step(0, 0, RET, 16'h0000, 16'h0000);
    expect_all("pop1", 16'h0022, 3'd0, 0, 0, 0);
    step(0, 0, RET, 16'h0000, 16'h0000);
    expect_all("unf", 16'h0022, 3'd0, 0, 1, 0);
    step(0, 0, HOLD, 16'h0000, 16'h0000);
    expect_all("unf_clr", 16'h0022, 3'd0, 0, 0, 0);

    // Stall freezes PC/stack and suppresses pulses
    step(0, 1, JUMP, 16'h1234, 16'h0000);
    expect_all("stall_jump", 16'h0022, 3'd0, 0, 0, 0);
    step(0, 1, CALL, 16'h4444, 16'h0000);
    expect_all("stall_call", 16'h0022, 3'd0, 0, 0, 0);
    step(0, 1, RSV1, 16'h0000, 16'h0000);
    expect_all("stall_rsv", 16'h0022, 3'd0, 0, 0, 0);
    step(0, 0, JUMP, 16'h1234, 16'h0000);
    expect_all("unstall", 16'h1234, 3'd0, 0, 0, 0);

    // Reserved ops
    step(0, 0, RSV1, 16'hAAAA, 16'h0001);
    expect_all("rsv111", 16'h1234, 3'd0, 0, 0, 1);
    step(0, 0, HOLD, 16'h0000, 16'h0000);
    expect_all("rsv_clr", 16'h1234, 3'd0, 0, 0, 0);
    step(0, 0, RSV0, 16'hAAAA, 16'h0001);
    expect_all("rsv110", 16'h1234, 3'd0, 0, 0, 1);

    // Mid-run reset discards the stack
    step(0, 0, CALL, 16'h0700, 16'h0000);
    step(0, 0, CALL, 16'h0800, 16'h0000);
    step(0, 0, CALL, 16'h0900, 16'h0000);
    expect_all("pre_rst", 16'h0900, 3'd3, 0, 0, 0);
    step(1, 0, CALL, 16'h0A00, 16'h0000);
    expect_all("mid_rst", 16'h0000, 3'd0, 0, 0, 0);
    step(0, 0, RET, 16'h0000, 16'h0000);
    expect_all("rst_unf", 16'h0000, 3'd0, 0, 1, 0);

`ifdef PC_BRANCH_TRACE_EN
    check("trace_mid_rst_vld", 32'(bus.br_vld), 32'h0);
    step(0, 0, JUMP, 16'h0005, 16'h0000);
    step(0, 0, JUMP, 16'h0040, 16'h0000);
    check("trace_src", 32'(bus.br_src), 32'h0005);
    check("trace_vld", 32'(bus.br_vld), 32'h1);
    step(0, 0, INC, 16'h0000, 16'h0000);
    check("trace_inc_src", 32'(bus.br_src), 32'h0005);
    step(0, 0, RET, 16'h0000, 16'h0000);
    check("trace_unf_src", 32'(bus.br_src), 32'h0005);
    step(0, 0, BRANCH, 16'h0000, 16'h0010);
    check("trace_br_src", 32'(bus.br_src), 32'h0041);
    check("trace_br_vld", 32'(bus.br_vld), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
